pong_round_controller: RTL and testbench

- Game-level sequencer for the VGA pong datapath; runs on the same clock as the processor wrapper and the paddle/ball logic.
- Walks the match through idle, serve countdown, live play, point celebration and game over.
- Gates the processor's ball update and the paddle movement, and forces the ball back to its initial position between points.
- Keeps both player scores. The p1 score feeds the seven-segment decoder; a winner is declared at WIN_SCORE points.

---
 rtl/pong_round_controller.sv | 176 +++++++++++++++++
 tb/tb_pong_round_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_round_controller.sv
`default_nettype none
// ============================================================================
//  Module   : pong_round_controller
//  Brief    : Match sequencer for the VGA pong datapath. Walks the game through
//             idle, serve countdown, live play, point celebration and game over.
//             It gates ball/paddle updates and keeps both player scores.
//  Revision : 1.0 - initial release
// ============================================================================
module pong_round_controller #(
    parameter int SERVE_FRAMES = 60,
    parameter int SCORE_FRAMES = 90,
    parameter int WIN_SCORE    = 3,
    parameter int SCORE_W      = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic [2:0]         winner,
    output logic               ball_hold,
    output logic               play_en,
    output logic               paddle_en,
    output logic               flash,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               game_over,
    output logic [1:0]         champion,
    output logic [2:0]         state
);

    // The timer only has to reach the longer hold minus one. It is kept at
    // least 4 bits wide so that the celebration blink can always use bit 3.
    localparam int c_TMAX    = (SERVE_FRAMES > SCORE_FRAMES) ? SERVE_FRAMES : SCORE_FRAMES;
    localparam int c_TW_RAW  = $clog2(c_TMAX);
    localparam int c_TW      = (c_TW_RAW < 4) ? 4 : c_TW_RAW;

    localparam logic [c_TW-1:0]    c_SERVE_LAST = c_TW'(SERVE_FRAMES - 1);
    localparam logic [c_TW-1:0]    c_SCORE_LAST = c_TW'(SCORE_FRAMES - 1);
    localparam logic [SCORE_W-1:0] c_WIN        = SCORE_W'(WIN_SCORE);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_SERVE    = 3'd1;
    localparam logic [2:0] c_PLAY     = 3'd2;
    localparam logic [2:0] c_SCORED   = 3'd3;
    localparam logic [2:0] c_GAMEOVER = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_nextState;
    logic [c_TW-1:0]    r_timer;
    logic [SCORE_W-1:0] r_p1Score;
    logic [SCORE_W-1:0] r_p2Score;
    logic [1:0]         r_champion;
    logic               r_startQ;

    logic               w_startPulse;
    logic               w_p1Point;
    logic               w_p2Point;
    logic [SCORE_W-1:0] w_p1Inc;
    logic [SCORE_W-1:0] w_p2Inc;

    // A held button yields a single pulse; points only count on a frame tick.
    assign w_startPulse = start & ~r_startQ;
    assign w_p1Point    = frame_tick && (winner == 3'd1);
    assign w_p2Point    = frame_tick && (winner == 3'd2);
    assign w_p1Inc      = r_p1Score + 1'b1;
    assign w_p2Inc      = r_p2Score + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode. Unused encodings fall back to IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_startPulse) w_nextState = c_SERVE;
            end
            c_SERVE: begin
                if (frame_tick && (r_timer == c_SERVE_LAST)) w_nextState = c_PLAY;
            end
            c_PLAY: begin
                if (w_p1Point) begin
                    w_nextState = (w_p1Inc == c_WIN) ? c_GAMEOVER : c_SCORED;
                end else if (w_p2Point) begin
                    w_nextState = (w_p2Inc == c_WIN) ? c_GAMEOVER : c_SCORED;
                end
            end
            c_SCORED: begin
                if (frame_tick && (r_timer == c_SCORE_LAST)) w_nextState = c_SERVE;
            end
            c_GAMEOVER: begin
                if (w_startPulse) w_nextState = c_SERVE;
            end
            default: w_nextState = c_IDLE;
        endcase
    end

    // Frame timer, button history, scores and champion. The timer only runs
    // in the two timed holds and restarts from zero on every state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_startQ   <= 1'b0;
            r_timer    <= '0;
            r_p1Score  <= '0;
            r_p2Score  <= '0;
            r_champion <= 2'd0;
        end else begin
            r_startQ <= start;

            if (w_nextState != r_state) begin
                r_timer <= '0;
            end else if (frame_tick && ((r_state == c_SERVE) || (r_state == c_SCORED))) begin
                r_timer <= r_timer + 1'b1;
            end

            case (r_state)
                c_IDLE, c_GAMEOVER: begin
                    if (w_startPulse) begin
                        r_p1Score  <= '0;
                        r_p2Score  <= '0;
                        r_champion <= 2'd0;
                    end
                end
                c_PLAY: begin
                    if (w_p1Point) begin
                        r_p1Score <= w_p1Inc;
                        if (w_p1Inc == c_WIN) r_champion <= 2'd1;
                    end else if (w_p2Point) begin
                        r_p2Score <= w_p2Inc;
                        if (w_p2Inc == c_WIN) r_champion <= 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore output decode from registered state and timer only.
    always_comb begin
        ball_hold = 1'b1;
        play_en   = 1'b0;
        paddle_en = 1'b0;
        flash     = 1'b0;
        game_over = 1'b0;
        case (r_state)
            c_SERVE: begin
                paddle_en = 1'b1;
            end
            c_PLAY: begin
                ball_hold = 1'b0;
                play_en   = 1'b1;
                paddle_en = 1'b1;
            end
            c_SCORED: begin
                flash = r_timer[3];
            end
            c_GAMEOVER: begin
                game_over = 1'b1;
            end
            default: ;
        endcase
    end

    assign p1_score = r_p1Score;
    assign p2_score = r_p2Score;
    assign champion = r_champion;
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pong_round_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pong_round_controller
//  Brief    : Self-checking bench for pong_round_controller. A phase/tick-count
//             model of the match is compared with the DUT on every cycle,
//             directed scenarios pin key values, then random stimulus runs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pong_round_controller;

    localparam int SERVE_FRAMES = 60;
    localparam int SCORE_FRAMES = 90;
    localparam int WIN_SCORE    = 3;
    localparam int SCORE_W      = 3;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               frame_tick = 1'b0;
    logic               start = 1'b0;
    logic [2:0]         winner = 3'd0;
    logic               ball_hold;
    logic               play_en;
    logic               paddle_en;
    logic               flash;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic               game_over;
    logic [1:0]         champion;
    logic [2:0]         state;

    pong_round_controller #(
        .SERVE_FRAMES(SERVE_FRAMES),
        .SCORE_FRAMES(SCORE_FRAMES),
        .WIN_SCORE   (WIN_SCORE),
        .SCORE_W     (SCORE_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .start     (start),
        .winner    (winner),
        .ball_hold (ball_hold),
        .play_en   (play_en),
        .paddle_en (paddle_en),
        .flash     (flash),
        .p1_score  (p1_score),
        .p2_score  (p2_score),
        .game_over (game_over),
        .champion  (champion),
        .state     (state)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;
    bit checkEn = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nErrors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the match phase (0 idle, 1 serve, 2 play, 3 scored,
    // 4 game over), the number of frame ticks seen in the current hold,
    // scores and champion.
    int mMode = 0;
    int mTicks = 0;
    int mP1 = 0;
    int mP2 = 0;
    int mChamp = 0;
    bit mPrevStart = 1'b0;

    function automatic void newMatch();
        mMode = 1; mTicks = 0; mP1 = 0; mP2 = 0; mChamp = 0;
    endfunction

    always @(posedge clk) begin
        bit pulse;
        pulse = start && !mPrevStart;
        mPrevStart = start;
        if (reset) begin
            mMode = 0; mTicks = 0; mP1 = 0; mP2 = 0; mChamp = 0; mPrevStart = 1'b0;
        end else begin
            case (mMode)
                0: if (pulse) newMatch();
                1: if (frame_tick) begin
                       mTicks++;
                       if (mTicks == SERVE_FRAMES) begin mMode = 2; mTicks = 0; end
                   end
                2: if (frame_tick && (winner == 3'd1 || winner == 3'd2)) begin
                       if (winner == 3'd1) mP1++; else mP2++;
                       mTicks = 0;
                       if (mP1 == WIN_SCORE)      begin mMode = 4; mChamp = 1; end
                       else if (mP2 == WIN_SCORE) begin mMode = 4; mChamp = 2; end
                       else                       mMode = 3;
                   end
                3: if (frame_tick) begin
                       mTicks++;
                       if (mTicks == SCORE_FRAMES) begin mMode = 1; mTicks = 0; end
                   end
                4: if (pulse) newMatch();
                default: mMode = 0;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            check("state",     int'(state),     mMode);
            check("ball_hold", int'(ball_hold), (mMode != 2) ? 1 : 0);
            check("play_en",   int'(play_en),   (mMode == 2) ? 1 : 0);
            check("paddle_en", int'(paddle_en), (mMode == 1 || mMode == 2) ? 1 : 0);
            check("flash",     int'(flash),     (mMode == 3 && ((mTicks / 8) % 2) == 1) ? 1 : 0);
            check("game_over", int'(game_over), (mMode == 4) ? 1 : 0);
            check("p1_score",  int'(p1_score),  mP1);
            check("p2_score",  int'(p2_score),  mP2);
            check("champion",  int'(champion),  mChamp);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Each tick is a one-cycle pulse followed by one idle cycle.
    task automatic tickN(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1; step();
            frame_tick = 1'b0; step();
        end
    endtask

    task automatic scorePoint(input logic [2:0] who);
        winner = who; frame_tick = 1'b1; step();
        winner = 3'd0; frame_tick = 1'b0; step();
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) step();
        checkEn = 1'b1;
        reset = 1'b0;
        step();
        check("lit reset state", int'(state), 0);
        check("lit reset ball_hold", int'(ball_hold), 1);

        // Start pulse -> SERVE, then the serve countdown.
        start = 1'b1; step(); start = 1'b0;
        check("lit serve state", int'(state), 1);
        check("lit serve ball_hold", int'(ball_hold), 1);
        tickN(SERVE_FRAMES - 1);
        check("lit serve 59 ticks", int'(state), 1);
        tickN(1);
        check("lit play state", int'(state), 2);
        check("lit play_en", int'(play_en), 1);

        // winner=1 held for 100 cycles with a single tick: one point only.
        winner = 3'd1; frame_tick = 1'b1; step(); frame_tick = 1'b0;
        repeat (99) step();
        winner = 3'd0;
        check("lit p1 one point", int'(p1_score), 1);
        check("lit scored state", int'(state), 3);
        tickN(SCORE_FRAMES);
        check("lit back to serve", int'(state), 1);
        tickN(SERVE_FRAMES);

        // Untimed winner=2 and unknown code 5 have no effect.
        winner = 3'd2; repeat (10) step();
        winner = 3'd5; frame_tick = 1'b1; step();
        frame_tick = 1'b0; winner = 3'd0; step();
        check("lit ignored p2", int'(p2_score), 0);
        check("lit ignored state", int'(state), 2);

        // p2 wins; start is held from before the final point.
        for (int k = 0; k < WIN_SCORE; k++) begin
            if (k == WIN_SCORE - 1) start = 1'b1;
            scorePoint(3'd2);
            if (k != WIN_SCORE - 1) begin
                tickN(SCORE_FRAMES);
                tickN(SERVE_FRAMES);
            end
        end
        repeat (5) step();
        check("lit gameover state", int'(state), 4);
        check("lit game_over", int'(game_over), 1);
        check("lit champion p2", int'(champion), 2);
        check("lit p2 three", int'(p2_score), 3);
        start = 1'b0; step();
        start = 1'b1; step(); start = 1'b0;
        check("lit restart state", int'(state), 1);
        check("lit restart p2", int'(p2_score), 0);
        check("lit restart champion", int'(champion), 0);

        // Reset in the middle of a celebration hold.
        tickN(SERVE_FRAMES);
        scorePoint(3'd1);
        tickN(40);
        reset = 1'b1; step(); reset = 1'b0;
        check("lit midreset state", int'(state), 0);
        check("lit midreset p1", int'(p1_score), 0);
        check("lit midreset flash", int'(flash), 0);
        check("lit midreset ball_hold", int'(ball_hold), 1);

        // Start held from reset: exactly one transition out of IDLE.
        reset = 1'b1; start = 1'b1; step();
        reset = 1'b0; step();
        check("lit held start serve", int'(state), 1);
        tickN(SERVE_FRAMES);
        scorePoint(3'd1);
        tickN(SCORE_FRAMES);
        check("lit held start no restart", int'(state), 1);
        start = 1'b0;

        // Random phase: frequent ticks, mostly-zero winner, sparse resets.
        for (int c = 0; c < 30000; c++) begin
            frame_tick = ($urandom_range(0, 2) == 0);
            winner     = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            if ($urandom_range(0, 199) == 0) start = ~start;
            reset      = ($urandom_range(0, 4999) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
